// File: rtl/adder_shift_mul_ctrl_if.sv
// adder_shift_mul_ctrl_if: start/operand request and busy/done/product response bundle of the multiplier sequencer
interface adder_shift_mul_ctrl_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  modport master (output start, a, b, input busy, done, product);
  modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/adder_shift_mul_ctrl.sv
// adder_shift_mul_ctrl: unsigned 4x4 shift-and-add multiplier sequenced around one 4-bit ripple adder; define MUL_ZERO_BYPASS_EN to finish zero-operand requests without CALC
module ripple_adder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [4:0] o_s
);
  logic [4:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_s[4] = w_c[4];
endmodule

module adder_shift_mul_ctrl #(
  parameter int ITER = 4
) (
  input logic               clk,
  input logic               rst_n,
  adder_shift_mul_ctrl_if.slave bus
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_mcand;
  logic [8:0]    r_acc;
  logic [CW-1:0] r_count;
  logic [7:0]    r_product;
  logic          w_accept, w_zero, w_last, w_unused;
  logic [3:0]    w_addend;
  logic [4:0]    w_sum;
  logic [8:0]    w_acc_shift;
  assign w_addend    = r_acc[0] ? r_mcand : 4'b0;
  ripple_adder4 u_add (.i_a(r_acc[7:4]), .i_b(w_addend), .o_s(w_sum));
  assign w_acc_shift = {1'b0, w_sum, r_acc[3:1]};
  assign w_last      = r_count == CW'(ITER - 1);
  assign w_accept    = bus.start && (r_state == IDLE || r_state == DONE);
`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero      = (bus.a == 4'd0) || (bus.b == 4'd0);
`else
  assign w_zero      = 1'b0;
`endif
  assign w_unused    = ^{r_acc[8], w_acc_shift[8]};
  assign bus.busy    = r_state == CALC;
  assign bus.done    = r_state == DONE;
  assign bus.product = r_product;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state: iterate in CALC, accept new requests from IDLE or DONE
  always_comb begin
    w_next = (r_state == CALC) ? (w_last ? DONE : CALC)
           : w_accept ? (w_zero ? DONE : CALC) : IDLE;
  end
  // operand capture, add-and-shift step, and product load on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= bus.a;
        r_acc   <= {5'b0, bus.b};
        r_count <= '0;
      end else if (r_state == CALC) begin
        r_acc   <= w_acc_shift;
        r_count <= r_count + 1'b1;
      end
      if (w_next == DONE) r_product <= w_accept ? 8'h00 : w_acc_shift[7:0];
    end
  end
endmodule

// File: tb/tb_adder_shift_mul_ctrl.sv
// tb_adder_shift_mul_ctrl: scoreboard bench comparing products, latency and busy time against a*b arithmetic
module tb_adder_shift_mul_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  adder_shift_mul_ctrl_if bus ();
  adder_shift_mul_ctrl #(.ITER(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic [7:0] p;
    int         cyc;
    int         lat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [7:0] hold = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.busy) busy_cnt++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int lat_of(input logic [3:0] x, input logic [3:0] y);
`ifdef MUL_ZERO_BYPASS_EN
    return (x == 4'd0 || y == 4'd0) ? 1 : 5;
`else
    return (x == 4'd0 && y == 4'd0) ? 5 : 5;
`endif
  endfunction
  // monitor: every done must match the oldest outstanding request; otherwise product must hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done product=%0h expected no done", bus.product);
        end else begin
          e = q.pop_front();
          chk("product", int'(bus.product), int'(e.p));
          chk("latency", cyc - e.cyc, e.lat);
          chk("busy_at_done", int'(bus.busy), 0);
          hold = e.p;
        end
      end else chk("product_hold", int'(bus.product), int'(hold));
    end
  end
  task automatic push_exp(input logic [3:0] x, input logic [3:0] y);
    exp_t n;
    n.p   = 8'(x) * 8'(y);
    n.cyc = cyc;
    n.lat = lat_of(x, y);
    q.push_back(n);
  endtask
  task automatic issue(input logic [3:0] x, input logic [3:0] y);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    push_exp(x, y);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask
  task automatic op(input logic [3:0] x, input logic [3:0] y);
    int b0 = busy_cnt;
    int l = lat_of(x, y);
    issue(x, y);
    wait_done();
    chk("busy_cycles", busy_cnt - b0, l == 1 ? 0 : 4);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int b0;
    bus.start = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_product", int'(bus.product), 0);
    rst_n = 1'b1;
    @(negedge clk);
    op(4'hF, 4'hF);
    op(4'h6, 4'h7);
    op(4'h1, 4'h1);
    op(4'h0, 4'h9);
    op(4'h9, 4'h0);
    // second start during CALC must be dropped
    b0 = busy_cnt;
    issue(4'h3, 4'h5);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'hF;
    bus.b = 4'hF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    chk("busy_cycles_ignored", busy_cnt - b0, 4);
    repeat (10) @(negedge clk);
    // start held high: back-to-back acceptance from DONE
    bus.start = 1'b1;
    bus.a = 4'h2;
    bus.b = 4'h3;
    push_exp(4'h2, 4'h3);
    @(negedge clk);
    wait_done();
    bus.a = 4'h4;
    bus.b = 4'h4;
    push_exp(4'h4, 4'h4);
    @(negedge clk);
    wait_done();
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    // asynchronous reset in the middle of CALC discards the operation
    bus.start = 1'b1;
    bus.a = 4'h9;
    bus.b = 4'h9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    hold = 8'h00;
    #1;
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_done", int'(bus.done), 0);
    chk("midreset_product", int'(bus.product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    op(4'h2, 4'h2);
    repeat (25) op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
